// File: rtl/mips_bus_arbiter.sv
// Two-master, one-slave Avalon-style bus arbiter: round-robin with grant parking
// and a stall watchdog that force-completes transfers the slave never finishes.
module mips_bus_arbiter #(
    parameter int          WAIT_TIMEOUT = 64,
    parameter logic [31:0] ERROR_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,

    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,

    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic [31:0] s_readdata,
    input  logic        s_waitrequest,

    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    typedef struct packed {
        logic [31:0] address;
        logic        read;
        logic        write;
        logic [31:0] writedata;
        logic [3:0]  byteenable;
    } bus_req_t;

    localparam logic [15:0] WD_LAST = 16'(WAIT_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        last;
    logic [15:0] wd_cnt;

    bus_req_t    mreq [2];
    logic [1:0]  req;
    logic        own, gsel;
    logic        req_g, req_o;
    logic        timeout, done;

    logic [1:0]        m_wait;
    logic [1:0][31:0]  m_rdata;

    assign mreq[0] = '{m0_address, m0_read, m0_write, m0_writedata, m0_byteenable};
    assign mreq[1] = '{m1_address, m1_read, m1_write, m1_writedata, m1_byteenable};
    assign req     = {m1_read | m1_write, m0_read | m0_write};

    assign own   = (state != IDLE);
    assign gsel  = (state == OWN1);
    assign req_g = req[gsel];
    assign req_o = req[~gsel];

    // Watchdog fires only on a genuinely stalled cycle; an on-time completion wins.
    assign timeout = own && req_g && s_waitrequest && (wd_cnt == WD_LAST);
    assign done    = own && req_g && (!s_waitrequest || timeout);

    // Slave side and master responses are purely combinational from state + inputs.
    always_comb begin
        s_address    = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_writedata  = '0;
        s_byteenable = '0;
        m_wait       = 2'b11;
        m_rdata      = '0;
        if (own) begin
            s_address    = mreq[gsel].address;
            s_read       = mreq[gsel].read  && !timeout;
            s_write      = mreq[gsel].write && !timeout;
            s_writedata  = mreq[gsel].writedata;
            s_byteenable = mreq[gsel].byteenable;
            m_wait[gsel] = s_waitrequest && !timeout;
            m_rdata[gsel] = (timeout && mreq[gsel].read) ? ERROR_DATA : s_readdata;
        end
    end

    assign m0_waitrequest = m_wait[0];
    assign m1_waitrequest = m_wait[1];
    assign m0_readdata    = m_rdata[0];
    assign m1_readdata    = m_rdata[1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req[0] && req[1]) state_nxt = last ? OWN0 : OWN1;
                else if (req[0])      state_nxt = OWN0;
                else if (req[1])      state_nxt = OWN1;
            end
            OWN0: if ((done || !req_g) && req_o) state_nxt = OWN1;
            OWN1: if ((done || !req_g) && req_o) state_nxt = OWN0;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            last      <= 1'b1;
            wd_cnt    <= '0;
            bus_error <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state && state_nxt != IDLE)
                last <= (state_nxt == OWN1);
            if (!own || done || state_nxt != state)
                wd_cnt <= '0;
            else if (req_g && s_waitrequest)
                wd_cnt <= wd_cnt + 16'd1;
            if (timeout)
                bus_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: grant order, parking, streaming, watchdog, async reset.
module tb_mips_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
    logic        bus_error;

    int n_assert = 0;
    int n_fail   = 0;

    mips_bus_arbiter #(.WAIT_TIMEOUT(8), .ERROR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        s_readdata = '0; s_waitrequest = 1'b1;

        // reset state
        tick();
        chk("rst_s_read", s_read, 0);
        chk("rst_s_write", s_write, 0);
        chk("rst_s_address", s_address, 0);
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_m0_rdata", m0_readdata, 0);
        chk("rst_bus_error", bus_error, 0);
        reset = 1'b0;

        // single m0 read with two stall cycles
        m0_read = 1; m0_address = 32'hBFC0_0000; m0_byteenable = 4'hF;
        #1 chk("t1_idle_no_s_read", s_read, 0);
        tick();
        chk("t1_s_read", s_read, 1);
        chk("t1_s_address", s_address, 32'hBFC0_0000);
        chk("t1_m0_wait_st1", m0_waitrequest, 1);
        tick();
        chk("t1_m0_wait_st2", m0_waitrequest, 1);
        tick();
        s_waitrequest = 0; s_readdata = 32'h2402_0005;
        #1 chk("t1_m0_wait_done", m0_waitrequest, 0);
        chk("t1_m0_rdata", m0_readdata, 32'h2402_0005);
        chk("t1_m1_wait", m1_waitrequest, 1);
        tick();
        m0_read = 0; s_waitrequest = 1;
        #1 chk("t1_parked_wait", m0_waitrequest, 1);
        chk("t1_parked_no_read", s_read, 0);

        // both request from IDLE: strict alternation 0,1,0,1
        reset = 1; tick(); reset = 0;
        s_waitrequest = 0;
        m0_read = 1; m0_address = 32'h0000_0A00;
        m1_read = 1; m1_address = 32'h0000_0A01;
        #1 chk("t2_idle_no_read", s_read, 0);
        tick();
        chk("t2_g1_addr", s_address, 32'h0000_0A00);
        chk("t2_g1_m1_wait", m1_waitrequest, 1);
        tick();
        chk("t2_g2_addr", s_address, 32'h0000_0A01);
        chk("t2_g2_m0_wait", m0_waitrequest, 1);
        tick();
        chk("t2_g3_addr", s_address, 32'h0000_0A00);
        tick();
        chk("t2_g4_addr", s_address, 32'h0000_0A01);
        chk("t2_g4_m1_wait", m1_waitrequest, 0);
        tick();
        m0_read = 0; m1_read = 0;

        // m1 write stream, arbiter parked on m0
        m1_write = 1; m1_address = 32'h0000_0010; m1_writedata = 32'hCAFE_F00D; m1_byteenable = 4'b0011;
        #1 chk("t3_not_yet", s_write, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_s_write", s_write, 1);
            chk("t3_s_be", s_byteenable, 4'b0011);
            chk("t3_s_wdata", s_writedata, 32'hCAFE_F00D);
            chk("t3_m1_wait", m1_waitrequest, 0);
        end
        m1_write = 0;
        #1 chk("t3_stream_end", s_write, 0);

        // move parking to m0, then m1 steals it while m0 waits
        m0_read = 1; m0_address = 32'h0000_0200;
        #1 chk("t6_switch_delay", s_read, 0);
        tick();
        chk("t6_m0_granted", s_read, 1);
        tick();
        m0_read = 0; s_waitrequest = 1;
        m1_write = 1; m1_address = 32'h0000_0300;
        #1 chk("t6_parked_m0_no_write", s_write, 0);
        tick();
        m0_read = 1;
        #1 chk("t6_m1_write", s_write, 1);
        chk("t6_m1_addr", s_address, 32'h0000_0300);
        chk("t6_m0_held", m0_waitrequest, 1);
        chk("t6_no_read", s_read, 0);
        tick();
        chk("t6_m0_still_held", m0_waitrequest, 1);
        s_waitrequest = 0;
        #1 chk("t6_m1_done", m1_waitrequest, 0);
        tick();
        m1_write = 0; s_waitrequest = 1;
        #1 chk("t6_m0_granted_after", s_read, 1);
        chk("t6_m0_addr", s_address, 32'h0000_0200);

        // watchdog: stall cycle 1 is now; forced completion on stall cycle 8
        chk("t4_stall1", m0_waitrequest, 1);
        for (int i = 2; i <= 7; i++) begin
            tick();
            chk("t4_stall_wait", m0_waitrequest, 1);
            chk("t4_stall_read", s_read, 1);
        end
        tick();
        chk("t4_to_wait", m0_waitrequest, 0);
        chk("t4_to_rdata", m0_readdata, 32'hDEAD_BEEF);
        chk("t4_to_s_read", s_read, 0);
        chk("t4_err_not_yet", bus_error, 0);
        tick();
        m0_read = 0;
        chk("t4_err_set", bus_error, 1);
        tick();
        chk("t4_err_sticky", bus_error, 1);

        // async reset during stalled m1 write
        m1_write = 1; m1_address = 32'h0000_0400;
        tick();
        chk("t5_s_write", s_write, 1);
        #2 reset = 1;
        #1 chk("t5_async_drop", s_write, 0);
        chk("t5_m1_wait", m1_waitrequest, 1);
        chk("t5_err_clr", bus_error, 0);
        tick();
        reset = 0; m1_write = 0;
        m0_read = 1; m0_address = 32'h0000_0500;
        #1 chk("t5_idle_m0_wait", m0_waitrequest, 1);
        chk("t5_idle_m1_wait", m1_waitrequest, 1);
        chk("t5_idle_no_read", s_read, 0);
        tick();
        chk("t5_after_grant", s_read, 1);
        m0_read = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
# mips_bus_arbiter

Two-master, one-slave arbiter for the MIPS Avalon-style memory bus (address/read/write/writedata/byteenable/readdata/waitrequest). It sits between `mips_cpu_bus` (master 0) and a second requester such as a program loader or DMA engine (master 1), sharing the downstream RAM/decoder bus between them. Arbitration is round-robin with grant parking, and a stall watchdog terminates transfers the slave never completes.

## Interface
- `WAIT_TIMEOUT`, 64: consecutive stalled cycles on a granted request before the watchdog forces completion; range 2..65535.
- `ERROR_DATA`, 32'hDEAD_BEEF: readdata returned on a watchdog-terminated read.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high.
- `m0_address`, `m1_address` in 32: master byte address.
- `m0_read`, `m0_write`, `m1_read`, `m1_write` in 1: request strobes; never both high for one master.
- `m0_writedata`, `m1_writedata` in 32: write data.
- `m0_byteenable`, `m1_byteenable` in 4: byte lanes.
- `m0_readdata`, `m1_readdata` out 32: read data to master.
- `m0_waitrequest`, `m1_waitrequest` out 1: stall to master.
- `s_address` out 32, `s_read` out 1, `s_write` out 1, `s_writedata` out 32, `s_byteenable` out 4: slave-side request.
- `s_readdata` in 32, `s_waitrequest` in 1: slave response.
- `bus_error` out 1: sticky, set by watchdog, cleared only by reset.

## Operation
- Request of master x: `req_x = mx_read | mx_write`. A transfer completes on a rising edge where the granted request is high and `s_waitrequest` is low; the master must hold all request signals stable while its waitrequest is high.
- States: IDLE, OWN0, OWN1. `last` register records the most recently granted master (reset value 1, so master 0 wins first tie).
- IDLE: slave strobes 0, both mx_waitrequest 1. If any req: next state OWN of the requester; both requesting -> OWN of master != `last`. No req -> stay.
- OWNx: slave outputs mux master x's signals; `mx_waitrequest = s_waitrequest`, `mx_readdata = s_readdata`; other master waitrequest 1, readdata 0. `last <= x` on entry.
- OWNx transitions: on completion, if other master requesting -> OWN other, else stay OWNx (park). If `req_x` low and other requesting -> OWN other. Neither requesting -> stay OWNx (parked; no IDLE return except by reset).
- Watchdog: 16-bit counter increments each cycle in OWNx with `req_x` high and `s_waitrequest` high; clears on completion or grant change. On the cycle the counter equals `WAIT_TIMEOUT-1`: `mx_waitrequest` forced 0, `mx_readdata = ERROR_DATA` if read, `s_read`/`s_write` forced 0, `bus_error` set next edge; treated as completion for transition purposes.
- In IDLE, s_address/s_writedata/s_byteenable drive 0; outside IDLE they follow the granted master even when its strobes are low.

## Timing
- Reset values: state IDLE, `last`=1, watchdog 0, `bus_error` 0, all s_* outputs 0, both mx_waitrequest 1, both mx_readdata 0. Async reset mid-transfer drops `s_read`/`s_write` immediately; the aborted transfer is not completed.
- Arbitration latency: request in IDLE or to a non-parked master reaches the slave 1 cycle later; request from the parked master reaches it the same cycle (combinational).
- Back-to-back from both masters: strict alternation, zero dead cycles between a completion and the other master's first request cycle.
- Single master streaming while parked: one transfer per cycle if slave never stalls.
- Slave outputs and mx_waitrequest/readdata are combinational from state + inputs; no registered data path.
- Watchdog: with slave stuck high, forced completion on the WAIT_TIMEOUT-th stalled cycle.

## Test plan
- Reset then m0 read 0xBFC0_0000, s_waitrequest high 2 cycles then low, s_readdata 0x2402_0005 -> s_read first high 1 cycle after req, m0 sees readdata 0x2402_0005 with m0_waitrequest low exactly once; m1_waitrequest stays 1.
- m0 and m1 both request from IDLE after reset -> m0 granted first; after its completion m1 granted next cycle; repeat 4 times -> grants alternate 0,1,0,1.
- m1 issues 3 writes (0x0000_0010, data 0xCAFE_F00D, byteenable 4'b0011) with m0 idle, slave never stalls -> 3 s_write cycles consecutive after initial grant cycle, byteenable passed through unchanged.
- WAIT_TIMEOUT=8, slave waitrequest stuck 1, m0 read -> on 8th stalled cycle m0_waitrequest 0, m0_readdata 0xDEAD_BEEF, s_read 0; bus_error 1 next edge and stays 1.
- Assert reset for one cycle while OWN1 write is stalled -> s_write falls without a clock edge; after release both waitrequests 1, state IDLE, bus_error 0.
- Parked on m0, m0 idle, m1 requests -> OWN1 one cycle later; m0 request arriving meanwhile waits until m1 completes.
